// File: rtl/instr_seq_ctrl_if.sv
// Sequencer-to-environment bundle: the fetch-block handshake plus datapath controls and status.
interface instr_seq_ctrl_if #(
  parameter int IW    = 8,
  parameter int JW    = 6,
  parameter int CNT_W = 16
);
  logic             start;
  logic             stall;
  logic [IW-1:0]    instr_code;
  logic             pc_en;
  logic             branch;
  logic [JW-1:0]    jmpaddr;
  logic             alu_op;
  logic [2:0]       rd;
  logic [2:0]       rs;
  logic             reg_we;
  logic             busy;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    input  start, stall, instr_code,
    output pc_en, branch, jmpaddr, alu_op, rd, rs, reg_we, busy, halted, retired
  );

  modport slave (
    output start, stall, instr_code,
    input  pc_en, branch, jmpaddr, alu_op, rd, rs, reg_we, busy, halted, retired
  );
endinterface

// File: rtl/instr_seq_ctrl.sv
// Four-cycle instruction sequencer: latches the word in FETCH, decodes it, and fires the
// PC-advance / branch / register-write strobes once per instruction in WB.
module instr_seq_ctrl #(
  parameter int IW    = 8,
  parameter int JW    = 6,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  instr_seq_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             wb_fire;
  logic [1:0]       op;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // A stalled WB simply stays in WB with its strobe masked, so the pulse fires exactly once
  // in the first unstalled cycle.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    wb_fire   = 1'b0;
    if (!bus.stall) begin
      case (state_q)
        S_IDLE:   if (bus.start) state_d = S_FETCH;
        S_FETCH: begin
          ir_d    = bus.instr_code;
          state_d = S_DECODE;
        end
        S_DECODE: state_d = (ir_q == '1) ? S_HALT : S_EXEC;
        S_EXEC:   state_d = S_WB;
        S_WB: begin
          wb_fire   = 1'b1;
          retired_d = sat_inc(retired_q);
          state_d   = S_FETCH;
        end
        S_HALT:   state_d = S_HALT;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  assign op          = ir_q[IW-1 -: 2];
  assign bus.pc_en   = wb_fire;
  assign bus.branch  = wb_fire && (op == 2'b10);
  assign bus.reg_we  = wb_fire && !op[1];
  assign bus.alu_op  = (op == 2'b01);
  assign bus.rd      = ir_q[5:3];
  assign bus.rs      = ir_q[2:0];
  assign bus.jmpaddr = ir_q[JW-1:0];
  assign bus.busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.halted  = (state_q == S_HALT);
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Scoreboarded bench: a small PC/memory model feeds the sequencer; expected WB strobes are queued
// by the stimulus and checked by independent monitors whenever pc_en appears.
module tb_instr_seq_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic rst_b;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_seq_ctrl_if #(.IW(8), .JW(6), .CNT_W(16)) a_if ();
  instr_seq_ctrl_if #(.IW(8), .JW(6), .CNT_W(2))  b_if ();

  instr_seq_ctrl #(.IW(8), .JW(6), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
  instr_seq_ctrl #(.IW(8), .JW(6), .CNT_W(2))  dut_b (.clk(clk), .reset(rst_b), .bus(b_if));

  // Fetch-block model for DUT A
  logic [7:0] mem [256];
  logic [7:0] pc;
  always @(posedge clk) begin
    if (reset) pc <= 8'h00;
    else if (a_if.pc_en) pc <= a_if.branch ? {pc[7:6], a_if.jmpaddr} : pc + 8'h01;
  end
  assign a_if.instr_code = mem[pc];
  assign b_if.instr_code = 8'h0A;

  typedef struct {
    int         cyc;
    logic       br;
    logic       we;
    logic       alu;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [5:0] jmp;
    logic [15:0] ret;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [1:0] ret;
  } expb_t;

  exp_t  qa[$];
  expb_t qb[$];
  exp_t  ea;
  expb_t eb;
  logic       pend_b = 1'b0;
  logic [1:0] pend_val;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push_a(input int c, input logic br, input logic we, input logic alu,
                        input logic [2:0] rd, input logic [2:0] rs, input logic [5:0] jmp,
                        input logic [15:0] ret);
    exp_t e;
    e.cyc = c; e.br = br; e.we = we; e.alu = alu;
    e.rd = rd; e.rs = rs; e.jmp = jmp; e.ret = ret;
    qa.push_back(e);
  endtask

  // Monitor A: every pc_en pulse must match the head of the expectation queue
  always @(negedge clk) begin
    if (a_if.pc_en) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse_a: pc_en at cyc %0d with nothing expected", cyc);
      end else begin
        ea = qa.pop_front();
        if (cyc != ea.cyc || a_if.branch !== ea.br || a_if.reg_we !== ea.we ||
            a_if.alu_op !== ea.alu || a_if.rd !== ea.rd || a_if.rs !== ea.rs ||
            a_if.jmpaddr !== ea.jmp || a_if.retired !== ea.ret) begin
          errors++;
          $display("FAIL wb_pulse_a: got cyc=%0d br=%b we=%b alu=%b rd=%0d rs=%0d jmp=%h ret=%0d; want cyc=%0d br=%b we=%b alu=%b rd=%0d rs=%0d jmp=%h ret=%0d",
                   cyc, a_if.branch, a_if.reg_we, a_if.alu_op, a_if.rd, a_if.rs, a_if.jmpaddr, a_if.retired,
                   ea.cyc, ea.br, ea.we, ea.alu, ea.rd, ea.rs, ea.jmp, ea.ret);
        end
      end
    end else if (a_if.branch || a_if.reg_we) begin
      checks++;
      errors++;
      $display("FAIL stray_strobe_a: br=%b we=%b without pc_en at cyc %0d", a_if.branch, a_if.reg_we, cyc);
    end
  end

  // Monitor B: pulse timing, then retired value one cycle after each pulse
  always @(negedge clk) begin
    if (pend_b) begin
      checks++;
      pend_b = 1'b0;
      if (b_if.retired !== pend_val) begin
        errors++;
        $display("FAIL retired_b: got %0d want %0d at cyc %0d", b_if.retired, pend_val, cyc);
      end
    end
    if (b_if.pc_en) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse_b: pc_en at cyc %0d", cyc);
      end else begin
        eb = qb.pop_front();
        if (cyc != eb.cyc) begin
          errors++;
          $display("FAIL pulse_cyc_b: got cyc %0d want %0d", cyc, eb.cyc);
        end
        pend_b   = 1'b1;
        pend_val = eb.ret;
      end
    end
  end

  initial begin
    int   k;
    logic bad;
    reset = 1'b1;
    rst_b = 1'b1;
    a_if.start = 1'b0; a_if.stall = 1'b0;
    b_if.start = 1'b0; b_if.stall = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    tick(2);

    chk("reset_outputs_a", {a_if.pc_en, a_if.branch, a_if.jmpaddr, a_if.alu_op, a_if.rd, a_if.rs,
                            a_if.reg_we, a_if.busy, a_if.halted}, 32'h0);
    chk("reset_retired_a", a_if.retired, 32'h0);
    chk("reset_retired_b", b_if.retired, 32'h0);
    reset = 1'b0;
    rst_b = 1'b0;
    tick(3);
    chk("idle_without_start", a_if.busy, 32'h0);

    // ADD, JMP 0x15, MOV, NOP, HALT
    mem[8'h00] = 8'h4B; mem[8'h01] = 8'h95;
    mem[8'h15] = 8'h0A; mem[8'h16] = 8'hC3; mem[8'h17] = 8'hFF;
    k = cyc;
    push_a(k + 4,  1'b0, 1'b1, 1'b1, 3'd1, 3'd3, 6'h0B, 16'd0);
    push_a(k + 8,  1'b1, 1'b0, 1'b0, 3'd2, 3'd5, 6'h15, 16'd1);
    push_a(k + 12, 1'b0, 1'b1, 1'b0, 3'd1, 3'd2, 6'h0A, 16'd2);
    push_a(k + 16, 1'b0, 1'b0, 1'b0, 3'd0, 3'd3, 6'h03, 16'd3);
    a_if.start = 1'b1;
    tick(1);
    a_if.start = 1'b0;
    wait_until(k + 5);
    chk("retired_after_first", a_if.retired, 32'd1);
    chk("busy_after_first", a_if.busy, 32'd1);
    wait_until(k + 20);
    chk("halted", a_if.halted, 32'd1);
    chk("halt_busy", a_if.busy, 32'd0);
    chk("halt_retired", a_if.retired, 32'd4);
    a_if.start = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (a_if.halted !== 1'b1 || a_if.busy !== 1'b0) bad = 1'b1;
    end
    a_if.start = 1'b0;
    chk("halt_ignores_start", bad, 32'd0);
    chk("halt_retired_hold", a_if.retired, 32'd4);

    // Stall held for three cycles once WB is reached
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("reset_from_halt", {a_if.halted, a_if.retired}, 32'h0);
    mem[8'h00] = 8'h0A; mem[8'h01] = 8'h4B; mem[8'h02] = 8'hFF;
    k = cyc;
    push_a(k + 7,  1'b0, 1'b1, 1'b0, 3'd1, 3'd2, 6'h0A, 16'd0);
    push_a(k + 11, 1'b0, 1'b1, 1'b1, 3'd1, 3'd3, 6'h0B, 16'd1);
    a_if.start = 1'b1;
    tick(1);
    a_if.start = 1'b0;
    wait_until(k + 4);
    a_if.stall = 1'b1;
    wait_until(k + 6);
    chk("stall_retired_frozen", a_if.retired, 32'd0);
    wait_until(k + 7);
    a_if.stall = 1'b0;
    wait_until(k + 15);
    chk("stall_halted", a_if.halted, 32'd1);
    chk("stall_retired", a_if.retired, 32'd2);

    // Reset wins over stall and start in EXEC
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    k = cyc;
    push_a(k + 4, 1'b0, 1'b1, 1'b0, 3'd1, 3'd2, 6'h0A, 16'd0);
    a_if.start = 1'b1;
    tick(1);
    a_if.start = 1'b0;
    wait_until(k + 7);
    chk("exec_decode", {a_if.busy, a_if.alu_op, a_if.rd, a_if.rs}, {24'h0, 1'b1, 1'b1, 3'd1, 3'd3});
    chk("exec_retired", a_if.retired, 32'd1);
    a_if.stall = 1'b1;
    a_if.start = 1'b1;
    reset = 1'b1;
    tick(1);
    chk("reset_in_exec_outputs", {a_if.pc_en, a_if.branch, a_if.jmpaddr, a_if.alu_op, a_if.rd, a_if.rs,
                                  a_if.reg_we, a_if.busy, a_if.halted}, 32'h0);
    chk("reset_in_exec_retired", a_if.retired, 32'h0);
    reset = 1'b0;
    a_if.stall = 1'b0;
    a_if.start = 1'b0;
    tick(6);
    chk("idle_after_reset", a_if.busy, 32'h0);

    // Two-bit counter saturates across five MOVs
    k = cyc;
    for (int i = 0; i < 5; i++) begin
      expb_t e;
      e.cyc = k + 4 + 4 * i;
      e.ret = (i < 3) ? 2'(i + 1) : 2'd3;
      qb.push_back(e);
    end
    b_if.start = 1'b1;
    tick(1);
    b_if.start = 1'b0;
    wait_until(k + 21);
    rst_b = 1'b1;
    tick(1);
    rst_b = 1'b0;
    chk("retired_b_after_reset", b_if.retired, 32'h0);
    tick(4);

    chk("queue_a_drained", qa.size(), 32'd0);
    chk("queue_b_drained", qb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
